// File: rtl/msg_router_pkg.sv
// Shared types and constants for the message router.
// Build option: MSG_ROUTER_CHK_EN adds a trailing checksum byte to each frame.
package msg_router_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT      = 3'd0,
        GET_ID    = 3'd1,
        GET_COUNT = 3'd2,
        PAYLOAD   = 3'd3,
        GET_CHK   = 3'd4
    } routerState_t;

    // Index width able to address n destinations (at least one bit).
    function automatic int unsigned idWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_timeout_timer.sv
// Idle-cycle watchdog: counts cycles while enabled, restarts on every byte,
// flags expiry when the idle run reaches TIMEOUT_CYCLES.
module msg_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Enable,
    input  logic Restart,
    output logic Expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idleCount;

    // Expiry is decoded from the registered count; a restart in the same cycle suppresses it.
    assign Expired = Enable && !Restart && (idleCount == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: cleared outside a frame, on a byte, or once it fires.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idleCount <= '0;
        end else if (!Enable || Restart || Expired) begin
            idleCount <= '0;
        end else begin
            idleCount <= idleCount + CNT_W'(1);
        end
    end

endmodule

// File: rtl/msg_router.sv
// Frames SYNC/ID/COUNT/payload messages from the serial byte stream and routes
// payload bytes to the addressed word receiver.
// Build option: MSG_ROUTER_CHK_EN appends a checksum byte (state GET_CHK).
module msg_router
    import msg_router_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned       NUM_DEST       = 4,
    parameter int unsigned       MAX_PAYLOAD    = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 50000
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [BYTE_W-1:0]   InByte,
    input  logic                InByteReady,
    output logic [BYTE_W-1:0]   DataByte,
    output logic [NUM_DEST-1:0] WriteByte,
    output logic [NUM_DEST-1:0] ClearAddr,
    output logic [NUM_DEST-1:0] MsgComplete,
    output logic                MsgError,
    output logic                Busy
);

    localparam int unsigned ID_W  = idWidth(NUM_DEST);
    localparam int unsigned REM_W = $clog2(MAX_PAYLOAD + 1);

`ifdef MSG_ROUTER_CHK_EN
    localparam routerState_t FRAME_END = GET_CHK;
`else
    localparam routerState_t FRAME_END = HUNT;
`endif

    routerState_t state, nextState;

    logic [ID_W-1:0]     destId, destIdD;
    logic [REM_W-1:0]    remaining, remainingD;
    logic [BYTE_W-1:0]   dataByteD;
    logic [NUM_DEST-1:0] writeByteD, clearAddrD, msgCompleteD;
    logic                msgErrorD, busyD;
    logic                timeoutExpired;

    logic                idValid, countTooBig, countZero, lastByte;
    logic [NUM_DEST-1:0] idMask, destMask;

`ifdef MSG_ROUTER_CHK_EN
    logic [BYTE_W-1:0]   chkSum, chkSumD;
    logic                chkOk;
    assign chkOk = (BYTE_W'(chkSum + InByte) == '0);
`endif

    assign idValid     = (32'(InByte) < NUM_DEST);
    assign countTooBig = (32'(InByte) > MAX_PAYLOAD);
    assign countZero   = (InByte == '0);
    assign lastByte    = (remaining == REM_W'(1));
    assign idMask      = NUM_DEST'(1) << InByte[ID_W-1:0];
    assign destMask    = NUM_DEST'(1) << destId;

    msg_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Enable  (state != HUNT),
        .Restart (InByteReady),
        .Expired (timeoutExpired)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= HUNT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: advance one field per strobe; errors and timeout fall back to HUNT.
    always_comb begin
        nextState = state;
        case (state)
            HUNT: begin
                if (InByteReady && (InByte == SYNC_BYTE)) nextState = GET_ID;
            end
            GET_ID: begin
                if (InByteReady) nextState = idValid ? GET_COUNT : HUNT;
            end
            GET_COUNT: begin
                if (InByteReady) begin
                    if (countTooBig)    nextState = HUNT;
                    else if (countZero) nextState = FRAME_END;
                    else                nextState = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (InByteReady && lastByte) nextState = FRAME_END;
            end
            GET_CHK: begin
                if (InByteReady) nextState = HUNT;
            end
            default: nextState = HUNT;
        endcase
        if (timeoutExpired) nextState = HUNT;
    end

    // Output and datapath next values; all pulses default low, bus and counters hold.
    always_comb begin
        dataByteD    = DataByte;
        writeByteD   = '0;
        clearAddrD   = '0;
        msgCompleteD = '0;
        msgErrorD    = 1'b0;
        busyD        = (nextState != HUNT);
        destIdD      = destId;
        remainingD   = remaining;
`ifdef MSG_ROUTER_CHK_EN
        chkSumD      = chkSum;
`endif
        case (state)
            GET_ID: begin
                if (InByteReady) begin
                    if (idValid) begin
                        clearAddrD = idMask;
                        destIdD    = ID_W'(InByte);
`ifdef MSG_ROUTER_CHK_EN
                        chkSumD    = InByte;
`endif
                    end else begin
                        msgErrorD = 1'b1;
                    end
                end
            end
            GET_COUNT: begin
                if (InByteReady) begin
                    if (countTooBig) begin
                        msgErrorD = 1'b1;
                    end else begin
                        remainingD = REM_W'(InByte);
`ifdef MSG_ROUTER_CHK_EN
                        chkSumD    = BYTE_W'(chkSum + InByte);
`else
                        if (countZero) msgCompleteD = destMask;
`endif
                    end
                end
            end
            PAYLOAD: begin
                if (InByteReady) begin
                    dataByteD  = InByte;
                    writeByteD = destMask;
                    remainingD = remaining - REM_W'(1);
`ifdef MSG_ROUTER_CHK_EN
                    chkSumD    = BYTE_W'(chkSum + InByte);
`else
                    if (lastByte) msgCompleteD = destMask;
`endif
                end
            end
            GET_CHK: begin
`ifdef MSG_ROUTER_CHK_EN
                if (InByteReady) begin
                    if (chkOk) msgCompleteD = destMask;
                    else       msgErrorD    = 1'b1;
                end
`endif
            end
            default: ;
        endcase
        if (timeoutExpired) msgErrorD = 1'b1;
    end

    // Output and datapath registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            DataByte    <= '0;
            WriteByte   <= '0;
            ClearAddr   <= '0;
            MsgComplete <= '0;
            MsgError    <= 1'b0;
            Busy        <= 1'b0;
            destId      <= '0;
            remaining   <= '0;
`ifdef MSG_ROUTER_CHK_EN
            chkSum      <= '0;
`endif
        end else begin
            DataByte    <= dataByteD;
            WriteByte   <= writeByteD;
            ClearAddr   <= clearAddrD;
            MsgComplete <= msgCompleteD;
            MsgError    <= msgErrorD;
            Busy        <= busyD;
            destId      <= destIdD;
            remaining   <= remainingD;
`ifdef MSG_ROUTER_CHK_EN
            chkSum      <= chkSumD;
`endif
        end
    end

endmodule

// File: tb/tb_msg_router.sv
// Bench for msg_router: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_msg_router;

    localparam int unsigned ND   = 4;
    localparam int unsigned MAXP = 32;
    localparam int unsigned TO   = 40;
    localparam logic [7:0]  SYNC = 8'hA5;
`ifdef MSG_ROUTER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic [7:0]    InByte;
    logic          InByteReady;
    logic [7:0]    DataByte;
    logic [ND-1:0] WriteByte, ClearAddr, MsgComplete;
    logic          MsgError, Busy;

    msg_router #(
        .SYNC_BYTE(SYNC), .NUM_DEST(ND), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InByte(InByte), .InByteReady(InByteReady),
        .DataByte(DataByte), .WriteByte(WriteByte), .ClearAddr(ClearAddr),
        .MsgComplete(MsgComplete), .MsgError(MsgError), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the current frame.
    logic [7:0]    expData = '0;
    logic [ND-1:0] expWr = '0, expClr = '0, expCmp = '0;
    logic          expErr = 1'b0, expBusy = 1'b0;
    bit            inFrame = 1'b0;
    logic [7:0]    frame[$];
    int            idle = 0, fid = 0, fcnt = 0;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            expData = '0; expWr = '0; expClr = '0; expCmp = '0; expErr = 1'b0; expBusy = 1'b0;
            inFrame = 1'b0; frame.delete(); idle = 0;
        end else begin
            expWr = '0; expClr = '0; expCmp = '0; expErr = 1'b0;
            if (InByteReady) begin
                idle = 0;
                if (!inFrame) begin
                    if (InByte == SYNC) begin
                        inFrame = 1'b1;
                        frame.delete();
                    end
                end else begin
                    int n, k, s;
                    frame.push_back(InByte);
                    n = frame.size();
                    if (n == 1) begin
                        if (int'(InByte) >= ND) begin
                            expErr = 1'b1; inFrame = 1'b0;
                        end else begin
                            fid = int'(InByte); expClr[fid] = 1'b1;
                        end
                    end else if (n == 2) begin
                        fcnt = int'(InByte);
                        if (fcnt > MAXP) begin
                            expErr = 1'b1; inFrame = 1'b0;
                        end else if (fcnt == 0 && !CHK) begin
                            expCmp[fid] = 1'b1; inFrame = 1'b0;
                        end
                    end else begin
                        k = n - 3;
                        if (k < fcnt) begin
                            expData = InByte; expWr[fid] = 1'b1;
                            if (k == fcnt - 1 && !CHK) begin
                                expCmp[fid] = 1'b1; inFrame = 1'b0;
                            end
                        end else begin
                            s = 0;
                            foreach (frame[i]) s += int'(frame[i]);
                            if (s % 256 == 0) expCmp[fid] = 1'b1;
                            else              expErr = 1'b1;
                            inFrame = 1'b0;
                        end
                    end
                end
            end else if (inFrame) begin
                idle++;
                if (idle >= TO) begin
                    expErr = 1'b1; inFrame = 1'b0;
                end
            end
            expBusy = inFrame;
        end
    end

    // Bench-side receivers and pulse tallies built from DUT outputs.
    logic [7:0] rxMem [ND][64];
    int rxAddr [ND];
    int clrCnt [ND];
    int wrCnt  [ND];
    int cmpCnt [ND];
    int errCnt = 0;

    // Per-cycle comparison against the model, plus receiver capture.
    always @(negedge Clock) begin
        check("DataByte",    32'(DataByte),    32'(expData));
        check("WriteByte",   32'(WriteByte),   32'(expWr));
        check("ClearAddr",   32'(ClearAddr),   32'(expClr));
        check("MsgComplete", 32'(MsgComplete), 32'(expCmp));
        check("MsgError",    32'(MsgError),    32'(expErr));
        check("Busy",        32'(Busy),        32'(expBusy));
        for (int d = 0; d < ND; d++) begin
            if (ClearAddr[d]) begin rxAddr[d] = 0; clrCnt[d]++; end
            if (WriteByte[d]) begin
                rxMem[d][rxAddr[d] & 63] = DataByte;
                rxAddr[d]++; wrCnt[d]++;
            end
            if (MsgComplete[d]) cmpCnt[d]++;
        end
        if (MsgError) errCnt++;
    end

    task automatic clearTallies();
        for (int d = 0; d < ND; d++) begin
            rxAddr[d] = 0; clrCnt[d] = 0; wrCnt[d] = 0; cmpCnt[d] = 0;
        end
        errCnt = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        InByteReady = 1'b1;
        InByte      = b;
        tick();
        InByteReady = 1'b0;
        InByte      = 8'($urandom);
        repeat (gap) tick();
    endtask

    // Sends SYNC/ID/COUNT/payload (+ checksum xor chkFlip when enabled).
    task automatic sendFrame(input logic [7:0] id, input logic [7:0] cnt,
                             input logic [7:0] p[$], input logic [7:0] chkFlip,
                             input int gapMax);
        logic [7:0] sum;
        sum = id + cnt;
        sendByte(SYNC, $urandom_range(0, gapMax));
        sendByte(id,   $urandom_range(0, gapMax));
        sendByte(cnt,  $urandom_range(0, gapMax));
        foreach (p[i]) begin
            sum = sum + p[i];
            sendByte(p[i], $urandom_range(0, gapMax));
        end
        if (CHK) sendByte(8'(-sum) ^ chkFlip, 0);
    endtask

    initial begin
        logic [7:0] p[$];
        Reset_n = 1'b0; InByteReady = 1'b0; InByte = '0;
        clearTallies();
        repeat (3) tick();
        check("rst_Busy",  32'(Busy), 0);
        check("rst_Data",  32'(DataByte), 0);
        check("rst_pulse", 32'({WriteByte, ClearAddr, MsgComplete, MsgError}), 0);
        Reset_n = 1'b1;
        repeat (2) tick();

        // 1: basic two-byte frame, back-to-back strobes
        clearTallies();
        p = '{8'h34, 8'h12};
        sendFrame(8'h02, 8'h02, p, 8'h00, 0);
        repeat (2) tick();
        check("t1_word",   32'({rxMem[2][1], rxMem[2][0]}), 32'h1234);
        check("t1_clr",    32'(clrCnt[2]), 1);
        check("t1_cmp",    32'(cmpCnt[2]), 1);
        check("t1_writes", 32'(wrCnt[2]), 2);

        // 2: noise before a frame is ignored
        clearTallies();
        sendByte(8'h00, 0); sendByte(8'hFF, 0); sendByte(8'h13, 1);
        check("t2_busy", 32'(Busy), 0);
        p = '{8'h7E};
        sendFrame(8'h01, 8'h01, p, 8'h00, 1);
        repeat (2) tick();
        check("t2_byte",   32'(rxMem[1][0]), 32'h7E);
        check("t2_writes", 32'(wrCnt[1]), 1);

        // 3: out-of-range ID, then a good frame
        clearTallies();
        sendByte(SYNC, 0); sendByte(8'h07, 2);
        check("t3_err", 32'(errCnt), 1);
        check("t3_clr", 32'(clrCnt[0] + clrCnt[1] + clrCnt[2] + clrCnt[3]), 0);
        p = '{8'h5A};
        sendFrame(8'h03, 8'h01, p, 8'h00, 0);
        repeat (2) tick();
        check("t3_byte", 32'(rxMem[3][0]), 32'h5A);
        check("t3_cmp",  32'(cmpCnt[3]), 1);

        // 4: COUNT over limit, then empty payload
        clearTallies();
        sendByte(SYNC, 0); sendByte(8'h00, 0); sendByte(8'h21, 2);
        check("t4_err", 32'(errCnt), 1);
        p.delete();
        sendFrame(8'h00, 8'h00, p, 8'h00, 0);
        repeat (2) tick();
        check("t4_cmp",    32'(cmpCnt[0]), 1);
        check("t4_writes", 32'(wrCnt[0]), 0);

        // 5: timeout mid-payload, then reset mid-frame
        clearTallies();
        sendByte(SYNC, 0); sendByte(8'h03, 0); sendByte(8'h02, 0); sendByte(8'hAA, 0);
        repeat (TO + 3) tick();
        check("t5_err",  32'(errCnt), 1);
        check("t5_cmp",  32'(cmpCnt[3]), 0);
        check("t5_busy", 32'(Busy), 0);
        sendByte(SYNC, 0); sendByte(8'h01, 0);
        Reset_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(Busy), 0);
        check("t5_rst_pulse", 32'({DataByte, WriteByte, ClearAddr, MsgComplete, MsgError}), 0);
        tick();
        Reset_n = 1'b1;
        repeat (2) tick();

`ifdef MSG_ROUTER_CHK_EN
        // 6: literal checksum frames
        clearTallies();
        sendByte(SYNC, 0); sendByte(8'h01, 0); sendByte(8'h02, 0);
        sendByte(8'h10, 0); sendByte(8'h20, 0); sendByte(8'hCD, 2);
        check("t6_cmp", 32'(cmpCnt[1]), 1);
        check("t6_err", 32'(errCnt), 0);
        clearTallies();
        sendByte(SYNC, 0); sendByte(8'h01, 0); sendByte(8'h02, 0);
        sendByte(8'h10, 0); sendByte(8'h20, 0); sendByte(8'hCE, 2);
        check("t6_bad_cmp", 32'(cmpCnt[1]), 0);
        check("t6_bad_err", 32'(errCnt), 1);
        check("t6_written", 32'(wrCnt[1]), 2);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 250; it++) begin
            int kind, gapMax, cnt, id;
            kind   = $urandom_range(0, 9);
            gapMax = ($urandom_range(0, 3) == 0) ? 0 : 3;
            id     = $urandom_range(0, ND - 1);
            cnt    = $urandom_range(0, MAXP);
            p.delete();
            for (int i = 0; i < cnt; i++)
                p.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
            case (kind)
                0: repeat ($urandom_range(1, 4)) sendByte(8'($urandom), $urandom_range(0, 2));
                1: begin sendByte(SYNC, 0); sendByte(8'($urandom_range(ND, 255)), 0); end
                2: begin
                    sendByte(SYNC, 0); sendByte(8'(id), 0);
                    sendByte(8'($urandom_range(MAXP + 1, 255)), 0);
                end
                3: begin
                    sendByte(SYNC, 0); sendByte(8'(id), 0); sendByte(8'(cnt + 1), 0);
                    repeat ($urandom_range(0, cnt)) sendByte(8'($urandom), 0);
                    repeat (TO + $urandom_range(0, 3)) tick();
                end
                4: begin
                    sendByte(SYNC, 0); sendByte(8'(id), TO - 1 + $urandom_range(0, 1));
                    sendByte(8'(cnt), 0);
                    foreach (p[i]) sendByte(p[i], 0);
                    if (CHK) sendByte(8'($urandom), 0);
                end
                5: sendFrame(8'(id), 8'(cnt), p, 8'($urandom_range(1, 255)), gapMax);
                default: sendFrame(8'(id), 8'(cnt), p, 8'h00, gapMax);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (TO + 5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
